// File: rtl/wiegand_pkg.sv
// wiegand_pkg: shared state encoding, counter-width helpers and the parity frame builder for WIEGAND_PARITY_EN
package wiegand_pkg;

    typedef enum logic [1:0] {IDLE, PULSE, SPACE, GAP} wg_state_t;

    localparam int WG_FN_W = 128;

    function automatic int wg_cnt_w(input int a, input int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction

    function automatic int wg_idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    // {even parity of upper payload half, payload, odd parity of lower half}
    function automatic logic [WG_FN_W-1:0] wg_frame_build(input logic [WG_FN_W-1:0] data, input int nbits);
        logic [WG_FN_W-1:0] ones;
        logic [WG_FN_W-1:0] pay;
        int p;
        int h;
        ones = '1;
        p = nbits - 2;
        h = p / 2;
        pay = data & ~(ones << p);
        return (pay << 1) | (WG_FN_W'(^(pay >> h)) << (p + 1)) | WG_FN_W'(~^(pay & ~(ones << h)));
    endfunction

endpackage

// File: rtl/wiegand_tick_gen.sv
// wiegand_tick_gen: CLK_DIV prescaler producing a one-clock tick strobe, restartable by clr
module wiegand_tick_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = cnt == W'(CLK_DIV - 1);

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;

endmodule

// File: rtl/wiegand_tx.sv
// wiegand_tx: Wiegand D0/D1 pulse transmitter, MSB first, with abort and post-frame gap; WIEGAND_PARITY_EN adds lead/trail parity bits
module wiegand_tx
    import wiegand_pkg::*;
#(
    parameter int MAX_BITS     = 64,
    parameter int CLK_DIV      = 1,
    parameter int PULSE_TICKS  = 500,
    parameter int PERIOD_TICKS = 2200,
    parameter int GAP_TICKS    = 20000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [6:0]          nbits,
    input  logic [MAX_BITS-1:0] data,
    output logic                busy,
    output logic                done,
    output logic                wg_d0,
    output logic                wg_d1
);

    localparam int CW = wg_cnt_w(PERIOD_TICKS, GAP_TICKS);
    localparam int IW = wg_idx_w(MAX_BITS);

    wg_state_t           state;
    logic [CW-1:0]       tcnt;
    logic [CW-1:0]       lim;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       first_idx;
    logic [MAX_BITS-1:0] sreg;
    logic [MAX_BITS-1:0] frame;
    logic [6:0]          n_eff;
    logic [6:0]          n_use;
    logic                tick;
    logic                go;

    assign n_eff = (int'(nbits) > MAX_BITS) ? 7'(MAX_BITS) : nbits;
`ifdef WIEGAND_PARITY_EN
    assign n_use = (n_eff < 7'd3) ? 7'd0 : n_eff;
    assign frame = MAX_BITS'(wg_frame_build(WG_FN_W'(data), int'(n_use)));
`else
    assign n_use = n_eff;
    assign frame = data;
`endif
    assign first_idx = IW'(n_use - 7'd1);
    assign go = state == IDLE && start && !abort;
    assign lim = state == PULSE ? CW'(PULSE_TICKS - 1) :
                 state == SPACE ? CW'(PERIOD_TICKS - PULSE_TICKS - 1) : CW'(GAP_TICKS - 1);

    wiegand_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (go),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            tcnt  <= '0;
            idx   <= '0;
            sreg  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            wg_d0 <= 1'b0;
            wg_d1 <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            tcnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            wg_d0 <= 1'b0;
            wg_d1 <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && n_use == '0)
                    done <= 1'b1;
                else if (start) begin
                    state <= PULSE;
                    tcnt  <= '0;
                    busy  <= 1'b1;
                    sreg  <= frame;
                    idx   <= first_idx;
                    wg_d1 <= frame[first_idx];
                    wg_d0 <= ~frame[first_idx];
                end
            end else if (tick && tcnt != lim)
                tcnt <= tcnt + 1'b1;
            else if (tick) begin
                tcnt <= '0;
                if (state == PULSE) begin
                    state <= SPACE;
                    wg_d0 <= 1'b0;
                    wg_d1 <= 1'b0;
                end else if (state == GAP) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else if (idx == '0)
                    state <= GAP;
                else begin
                    state <= PULSE;
                    idx   <= idx - 1'b1;
                    wg_d1 <= sreg[idx - 1'b1];
                    wg_d0 <= ~sreg[idx - 1'b1];
                end
            end
        end

endmodule

// File: tb/tb_wiegand_tx.sv
// tb_wiegand_tx: randomized self-checking bench comparing wiegand_tx line activity to a per-cycle timing model
module tb_wiegand_tx;

    localparam int MB = 64, PT = 5, PER = 22, GT = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [6:0]    nbits = '0;
    logic [MB-1:0] data = '0;
    logic          busy, done, wg_d0, wg_d1;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    wiegand_tx #(.MAX_BITS(MB), .CLK_DIV(1), .PULSE_TICKS(PT), .PERIOD_TICKS(PER), .GAP_TICKS(GT)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .nbits (nbits),
        .data  (data),
        .busy  (busy),
        .done  (done),
        .wg_d0 (wg_d0),
        .wg_d1 (wg_d1)
    );

    // Effective length and the exact bit string that should appear on the wire
    function automatic void model(input logic [6:0] nb, input logic [63:0] d, output int n, output logic [63:0] fr);
        n = int'(nb) > 64 ? 64 : int'(nb);
`ifdef WIEGAND_PARITY_EN
        if (n < 3) begin
            n = 0;
            fr = '0;
        end else begin
            int p, h;
            logic [63:0] pay, up, lo;
            p = n - 2;
            h = p / 2;
            pay = d & ((64'd1 << p) - 64'd1);
            up = pay >> h;
            lo = pay & ((64'd1 << h) - 64'd1);
            fr = pay << 1;
            fr[0] = ($countones(lo) % 2) == 0;
            fr[n-1] = ($countones(up) % 2) == 1;
        end
`else
        fr = n == 64 ? d : d & ((64'd1 << n) - 64'd1);
`endif
    endfunction

    task automatic launch(input logic [6:0] nb, input logic [63:0] d);
        @(negedge clk);
        nbits = nb;
        data = d;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Samples one cycle per k (k=0 is the cycle after start is accepted) against the ideal waveform
    task automatic capture(input int n, input logic [63:0] fr, input int cycles, input int poke_at,
                           output int line_err, output int busy_err, output int done_at, output int done_cnt,
                           output int p0, output int p1, output int both);
        logic l0, l1;
        int total;
        total = n == 0 ? 0 : n * PER + GT;
        l0 = 1'b0; l1 = 1'b0;
        line_err = 0; busy_err = 0; done_at = -1; done_cnt = 0; p0 = 0; p1 = 0; both = 0;
        for (int k = 0; k < cycles; k++) begin
            logic e0, e1;
            @(negedge clk);
            e0 = 1'b0;
            e1 = 1'b0;
            if (k < n * PER && k % PER < PT) begin
                e1 = fr[n - 1 - k / PER];
                e0 = ~e1;
            end
            if (wg_d0 !== e0 || wg_d1 !== e1) line_err++;
            if (busy !== (k < total)) busy_err++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (wg_d0 === 1'b1 && wg_d1 === 1'b1) both++;
            if (wg_d0 === 1'b1 && !l0) p0++;
            if (wg_d1 === 1'b1 && !l1) p1++;
            l0 = wg_d0 === 1'b1;
            l1 = wg_d1 === 1'b1;
            if (k == poke_at) begin
                start = 1'b1;
                data = {$urandom, $urandom};
                nbits = 7'($urandom_range(1, 127));
            end else
                start = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if ({wg_d0, wg_d1} !== 2'b00) begin errors++; $display("FAIL reset_lines: got %b%b expected 00", wg_d0, wg_d1); end
        rst = 1'b1;
    endtask

    task automatic test_basic;
        int n, le, be, da, dc, p0, p1, bo;
        logic [63:0] fr;
        model(7'd26, 64'h2AAAAAA, n, fr);
        launch(7'd26, 64'h2AAAAAA);
        capture(n, fr, n * PER + GT + 10, -1, le, be, da, dc, p0, p1, bo);
        checks++; if (le !== 0) begin errors++; $display("FAIL basic_lines: %0d bad cycles, expected 0", le); end
        checks++; if (da !== 26 * PER + GT) begin errors++; $display("FAIL basic_done_time: got %0d expected %0d", da, 26 * PER + GT); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", dc); end
        checks++; if (p1 !== $countones(fr)) begin errors++; $display("FAIL basic_d1_pulses: got %0d expected %0d", p1, $countones(fr)); end
        checks++; if (p0 !== n - $countones(fr)) begin errors++; $display("FAIL basic_d0_pulses: got %0d expected %0d", p0, n - $countones(fr)); end
        checks++; if (bo !== 0) begin errors++; $display("FAIL basic_both_high: got %0d expected 0", bo); end
    endtask

    task automatic test_full;
        int n, le, be, da, dc, p0, p1, bo;
        logic [63:0] fr;
        model(7'd64, '1, n, fr);
        launch(7'd64, '1);
        capture(n, fr, n * PER + GT + 5, -1, le, be, da, dc, p0, p1, bo);
        checks++; if (le !== 0) begin errors++; $display("FAIL full_lines: %0d bad cycles, expected 0", le); end
        checks++; if (be !== 0) begin errors++; $display("FAIL full_busy: %0d bad cycles, expected 0", be); end
        checks++; if (p0 !== n - $countones(fr)) begin errors++; $display("FAIL full_d0_pulses: got %0d expected %0d", p0, n - $countones(fr)); end
        checks++; if (p1 !== $countones(fr)) begin errors++; $display("FAIL full_d1_pulses: got %0d expected %0d", p1, $countones(fr)); end
    endtask

    task automatic test_lengths;
        int n, le, be, da, dc, p0, p1, bo;
        logic [63:0] fr, d;
        launch(7'd0, {$urandom, $urandom});
        capture(0, '0, 30, -1, le, be, da, dc, p0, p1, bo);
        checks++; if (da !== 0) begin errors++; $display("FAIL zero_done_time: got %0d expected 0", da); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", dc); end
        checks++; if (p0 + p1 !== 0) begin errors++; $display("FAIL zero_pulses: got %0d expected 0", p0 + p1); end
        checks++; if (be !== 0) begin errors++; $display("FAIL zero_busy: %0d bad cycles, expected 0", be); end
        d = {$urandom, $urandom};
        model(7'd100, d, n, fr);
        launch(7'd100, d);
        capture(n, fr, n * PER + GT + 5, -1, le, be, da, dc, p0, p1, bo);
        checks++; if (p0 + p1 !== 64) begin errors++; $display("FAIL clamp_pulses: got %0d expected 64", p0 + p1); end
        checks++; if (le !== 0) begin errors++; $display("FAIL clamp_lines: %0d bad cycles, expected 0", le); end
    endtask

    task automatic test_back_to_back;
        int n, le, be, da, dc, p0, p1, bo;
        logic [63:0] fr, d;
        d = {$urandom, $urandom};
        model(7'd26, d, n, fr);
        launch(7'd26, d);
        capture(n, fr, n * PER + GT + 5, 100, le, be, da, dc, p0, p1, bo);
        checks++; if (le !== 0) begin errors++; $display("FAIL restart_lines: %0d bad cycles, expected 0", le); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL restart_done_count: got %0d expected 1", dc); end
        d = {$urandom, $urandom};
        model(7'd8, d, n, fr);
        launch(7'd8, d);
        capture(n, fr, n * PER + GT + 5, -1, le, be, da, dc, p0, p1, bo);
        checks++; if (le !== 0) begin errors++; $display("FAIL next_lines: %0d bad cycles, expected 0", le); end
        checks++; if (da !== n * PER + GT) begin errors++; $display("FAIL next_done_time: got %0d expected %0d", da, n * PER + GT); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 4; i++) begin
            int n, le, be, da, dc, p0, p1, bo, exp_da;
            logic [63:0] fr, d;
            logic [6:0] nb;
            nb = 7'($urandom_range(1, 64));
            d = {$urandom, $urandom};
            model(nb, d, n, fr);
            exp_da = n == 0 ? 0 : n * PER + GT;
            launch(nb, d);
            capture(n, fr, exp_da + 5, -1, le, be, da, dc, p0, p1, bo);
            checks++; if (le !== 0) begin errors++; $display("FAIL random_lines nbits=%0d: %0d bad cycles, expected 0", nb, le); end
            checks++; if (da !== exp_da) begin errors++; $display("FAIL random_done_time nbits=%0d: got %0d expected %0d", nb, da, exp_da); end
            checks++; if (be !== 0) begin errors++; $display("FAIL random_busy nbits=%0d: %0d bad cycles, expected 0", nb, be); end
        end
    endtask

    task automatic test_abort;
        int seen;
        launch(7'd26, {$urandom, $urandom});
        repeat (47) @(negedge clk);
        checks++; if ((wg_d0 | wg_d1) !== 1'b1) begin errors++; $display("FAIL abort_pulse_active: got %b%b expected one high", wg_d0, wg_d1); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if ({wg_d0, wg_d1} !== 2'b00) begin errors++; $display("FAIL abort_lines: got %b%b expected 00", wg_d0, wg_d1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        seen = 0;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if (done === 1'b1 || wg_d0 === 1'b1 || wg_d1 === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", seen); end
        nbits = 7'd26;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy === 1'b1 || done === 1'b1 || wg_d0 === 1'b1 || wg_d1 === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_start_same_cycle: got %0d active cycles expected 0", seen); end
    endtask

    task automatic test_reset_mid;
        int seen;
        launch(7'd26, {$urandom, $urandom});
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if ({busy, done, wg_d0, wg_d1} !== 4'b0000) begin errors++; $display("FAIL rst_pulse_outputs: got %b expected 0000", {busy, done, wg_d0, wg_d1}); end
        @(negedge clk);
        rst = 1'b1;
        launch(7'd3, {$urandom, $urandom});
        repeat (101) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy: got %b expected 1", busy); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({busy, done, wg_d0, wg_d1} !== 4'b0000) begin errors++; $display("FAIL rst_gap_outputs: got %b expected 0000", {busy, done, wg_d0, wg_d1}); end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1 || wg_d0 === 1'b1 || wg_d1 === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_gap_quiet: got %0d active cycles expected 0", seen); end
    endtask

`ifdef WIEGAND_PARITY_EN
    task automatic test_parity;
        int le, be, da, dc, p0, p1, bo;
        launch(7'd26, 64'h000001);
        capture(26, 64'h0000002, 26 * PER + GT + 5, -1, le, be, da, dc, p0, p1, bo);
        checks++; if (le !== 0) begin errors++; $display("FAIL parity_low_lines: %0d bad cycles, expected 0", le); end
        checks++; if (p1 !== 1) begin errors++; $display("FAIL parity_low_d1: got %0d expected 1", p1); end
        launch(7'd26, 64'h001000);
        capture(26, 64'h2002001, 26 * PER + GT + 5, -1, le, be, da, dc, p0, p1, bo);
        checks++; if (le !== 0) begin errors++; $display("FAIL parity_high_lines: %0d bad cycles, expected 0", le); end
        checks++; if (p1 !== 3) begin errors++; $display("FAIL parity_high_d1: got %0d expected 3", p1); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_lengths();
        test_back_to_back();
        test_random();
        test_abort();
        test_reset_mid();
`ifdef WIEGAND_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
